// File: rtl/mips_trace_monitor.sv
// Retire-trace monitor: classifies retiring MIPS instructions, keeps saturating class counters
// and buffers {pc, class, wd} records in a FWFT FIFO. Define MIPS_TRACE_TSTAMP_EN for per-record timestamps.
module mips_trace_monitor #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       retire_valid,
   input  logic [PC_W-1:0]            retire_pc,
   input  logic [5:0]                 retire_opcode,
   input  logic [5:0]                 retire_funct,
   input  logic [DATA_W-1:0]          retire_wd,
   input  logic                       trace_en,
   input  logic                       cnt_clr,
   input  logic [3:0]                 cnt_sel,
   output logic [CNT_W-1:0]           cnt_value,
   output logic                       tr_valid,
   input  logic                       tr_ready,
   output logic [PC_W-1:0]            tr_pc,
   output logic [3:0]                 tr_class,
   output logic [DATA_W-1:0]          tr_wd,
   output logic [CNT_W-1:0]           tr_tstamp,
   output logic [$clog2(DEPTH):0]     tr_level,
   output logic                       tr_overflow
);
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int NCNT = 11;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [3:0] cls;
   logic [3:0] cnt_idx;

   always_comb begin
      cls = 4'd15;
      unique case (retire_opcode)
         6'd0: begin
            unique case (retire_funct)
               6'd32:   cls = 4'd0;
               6'd34:   cls = 4'd1;
               6'd36:   cls = 4'd2;
               6'd37:   cls = 4'd3;
               default: cls = 4'd15;
            endcase
         end
         6'd35:   cls = 4'd4;
         6'd43:   cls = 4'd5;
         6'd4:    cls = 4'd6;
         6'd2:    cls = 4'd7;
         default: cls = 4'd15;
      endcase
      cnt_idx = cls[3] ? 4'd8 : cls;
   end

   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             push, pop, full, wr_en, drop;

   assign full  = (level_q == FULL_LVL);
   assign push  = retire_valid & trace_en;
   assign pop   = (level_q != '0) & tr_ready;
   // a full FIFO still accepts a push when the head leaves on the same edge
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      for (int i = 0; i < NCNT; i++) cnt_d[i] = cnt_q[i];
      ovf_d = ovf_q;
      if (cnt_clr) begin
         for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
         ovf_d = 1'b0;
      end else begin
         if (retire_valid) begin
            cnt_d[cnt_idx] = sat_inc(cnt_q[cnt_idx]);
            cnt_d[9]       = sat_inc(cnt_q[9]);
         end
         if (drop) begin
            cnt_d[10] = sat_inc(cnt_q[10]);
            ovf_d     = 1'b1;
         end
      end
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop)      level_d = level_q + LVL_ONE;
      else if (!wr_en && pop) level_d = level_q - LVL_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   logic [PC_W-1:0]   mem_pc_q  [DEPTH];
   logic [3:0]        mem_cls_q [DEPTH];
   logic [DATA_W-1:0] mem_wd_q  [DEPTH];

   // storage needs no reset: outputs are gated by occupancy
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc_q[wr_ptr_q]  <= retire_pc;
         mem_cls_q[wr_ptr_q] <= cls;
         mem_wd_q[wr_ptr_q]  <= retire_wd;
      end
   end

   always_comb begin
      cnt_value = '0;
      for (int i = 0; i < NCNT; i++)
         if (cnt_sel == 4'(i)) cnt_value = cnt_q[i];
   end

   assign tr_valid    = (level_q != '0);
   assign tr_pc       = tr_valid ? mem_pc_q[rd_ptr_q]  : '0;
   assign tr_class    = tr_valid ? mem_cls_q[rd_ptr_q] : '0;
   assign tr_wd       = tr_valid ? mem_wd_q[rd_ptr_q]  : '0;
   assign tr_level    = level_q;
   assign tr_overflow = ovf_q;

`ifdef MIPS_TRACE_TSTAMP_EN
   logic [CNT_W-1:0] ts_q, ts_d;
   logic [CNT_W-1:0] mem_ts_q [DEPTH];

   always_comb ts_d = ts_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_q <= '0;
      else      ts_q <= ts_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_ts_q[wr_ptr_q] <= ts_q;
   end

   assign tr_tstamp = tr_valid ? mem_ts_q[rd_ptr_q] : '0;
`else
   assign tr_tstamp = '0;
`endif

endmodule
